// File: rtl/regfile_wb_pkg.sv
// Shared constants for the register file / writeback stage and the Execution unit.
// Holds the datapath geometry, the condition-code reset value and the NPZ bit positions.
package regfile_wb_pkg;

  localparam int DATA_W = 16;
  localparam int REG_COUNT = 8;
  localparam int ADDR_W = $clog2(REG_COUNT);
  localparam int CC_W = 3;
  localparam logic [CC_W-1:0] CC_RESET = 3'b001;

  // Bit positions inside an NPZ / CC word.
  localparam int NPZ_N = 2;
  localparam int NPZ_P = 1;
  localparam int NPZ_Z = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits tracking outstanding writes between issue and commit.
// Lookups already discount a clear landing at this edge so decode never stalls on it.
module regfile_scoreboard
  import regfile_wb_pkg::*;
#(
  parameter int REG_COUNT_P = REG_COUNT,
  parameter int ADDR_W_P = $clog2(REG_COUNT_P)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                issue_valid,
  input  logic [ADDR_W_P-1:0] issue_dr,
  input  logic                clr_en,
  input  logic [ADDR_W_P-1:0] clr_dr,
  input  logic [ADDR_W_P-1:0] sr1,
  input  logic [ADDR_W_P-1:0] sr2,
  output logic                rs1_busy,
  output logic                rs2_busy,
  output logic                dr_busy
);

  logic [REG_COUNT_P-1:0] busy;
  logic                   set_en;

  assign rs1_busy = busy[sr1] & ~(clr_en && clr_dr == sr1);
  assign rs2_busy = busy[sr2] & ~(clr_en && clr_dr == sr2);
  assign dr_busy  = busy[issue_dr] & ~(clr_en && clr_dr == issue_dr);
  assign set_en   = issue_valid & ~dr_busy;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy <= '0;
    end else begin
      // NOTE: both updates are non-blocking to the same vector; the later one
      // (set) wins when they hit the same bit, which is the intended priority.
      if (clr_en) busy[clr_dr] <= 1'b0;
      if (set_en) busy[issue_dr] <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb.sv
// General register array, condition-code register and writeback commit port.
// Reads are combinational with a write-first bypass from the committing result.
module regfile_wb
  import regfile_wb_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int REG_COUNT_P = REG_COUNT,
  parameter logic [CC_W-1:0] CC_RESET_P = CC_RESET,
  parameter int ADDR_W_P = $clog2(REG_COUNT_P)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                wb_valid,
  output logic                wb_ready,
  input  logic                hold,
  input  logic [ADDR_W_P-1:0] wb_dr,
  input  logic [DATA_W_P-1:0] wb_data,
  input  logic [CC_W-1:0]     wb_npz,
  input  logic                wb_write_reg,
  input  logic                wb_set_cc,
  input  logic                issue_valid,
  input  logic [ADDR_W_P-1:0] issue_dr,
  input  logic [ADDR_W_P-1:0] sr1,
  input  logic [ADDR_W_P-1:0] sr2,
  output logic [DATA_W_P-1:0] rs1_data,
  output logic [DATA_W_P-1:0] rs2_data,
  output logic                rs1_busy,
  output logic                rs2_busy,
  output logic                dr_busy,
  output logic [CC_W-1:0]     cc
);

  logic [DATA_W_P-1:0] regs [REG_COUNT_P];
  logic                commit;
  logic                reg_wr;

  assign wb_ready = ~hold;
  assign commit   = wb_valid & wb_ready;
  assign reg_wr   = commit & wb_write_reg;

  assign rs1_data = (reg_wr && wb_dr == sr1) ? wb_data : regs[sr1];
  assign rs2_data = (reg_wr && wb_dr == sr2) ? wb_data : regs[sr2];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: the array is architecturally visible after reset (reads must return 0),
      // so every entry is reset explicitly rather than left as an unreset RAM.
      for (int i = 0; i < REG_COUNT_P; i++) regs[i] <= '0;
      cc <= CC_RESET_P;
    end else begin
      if (reg_wr) regs[wb_dr] <= wb_data;
      // NPZ is loaded as-is; a malformed flag word is the producer's problem.
      if (commit && wb_set_cc) cc <= wb_npz;
    end
  end

  regfile_scoreboard #(
    .REG_COUNT_P (REG_COUNT_P),
    .ADDR_W_P    (ADDR_W_P)
  ) u_scoreboard (
    .clk         (clk),
    .reset_n     (reset_n),
    .issue_valid (issue_valid),
    .issue_dr    (issue_dr),
    .clr_en      (reg_wr),
    .clr_dr      (wb_dr),
    .sr1         (sr1),
    .sr2         (sr2),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .dr_busy     (dr_busy)
  );

endmodule

// File: doc/regfile_wb.md
REGFILE_WB -- requirements
Module: regfile_wb

Interface
REQ-001 Parameter: DATA_W, 16, register and data width.
REQ-002 Parameter: REG_COUNT, 8, number of general registers; addresses are 3 bits.
REQ-003 Parameter: CC_RESET, 3'b001, condition-code value after reset (Z set).
REQ-004 CLK  in  1  single clock; all state updates on rising edge.
REQ-005 RESET_N  in  1  reset, synchronous, active-low.
REQ-006 WB_VALID  in  1  Execution result offered for commit this cycle.
REQ-007 WB_READY  out  1  commit accepted; equals ~HOLD.
REQ-008 HOLD  in  1  downstream/memory busy; blocks commit.
REQ-009 WB_DR  in  3  destination register (IR[11:9] from issuing instruction).
REQ-010 WB_DATA  in  DATA_W  Execution Y result.
REQ-011 WB_NPZ  in  3  Execution NPZ flags; bit2 N, bit1 P, bit0 Z.
REQ-012 WB_WRITE_REG  in  1  commit writes WB_DATA into WB_DR.
REQ-013 WB_SET_CC  in  1  commit loads WB_NPZ into CC register.
REQ-014 ISSUE_VALID  in  1  decode issues an instruction that will write ISSUE_DR.
REQ-015 ISSUE_DR  in  3  destination of issued instruction.
REQ-016 SR1, SR2  in  3 each  source read addresses.
REQ-017 RS1_DATA, RS2_DATA  out  DATA_W each  read data feeding Execution RS1_DATA/RS2_DATA.
REQ-018 RS1_BUSY, RS2_BUSY, DR_BUSY  out  1 each  scoreboard hazard flags for SR1, SR2, ISSUE_DR.
REQ-019 CC  out  3  current condition-code register.

Function
REQ-020 Commit SHALL occur in a cycle iff WB_VALID & WB_READY.
REQ-021 On commit with WB_WRITE_REG, register[WB_DR] SHALL take WB_DATA at the clock edge.
REQ-022 On commit with WB_SET_CC, CC SHALL take WB_NPZ at the clock edge; otherwise CC holds.
REQ-023 WB_NPZ not exactly one-hot on a CC load SHALL still be loaded unmodified (no correction).
REQ-024 Reads SHALL be combinational; RSx_DATA = register[SRx], except write-first bypass: if commit & WB_WRITE_REG & WB_DR==SRx, RSx_DATA = WB_DATA in the same cycle.
REQ-025 Scoreboard: one busy bit per register, all 0 after reset.
REQ-026 ISSUE_VALID & ~DR_BUSY SHALL set busy[ISSUE_DR] at the clock edge.
REQ-027 Commit with WB_WRITE_REG SHALL clear busy[WB_DR] at the clock edge.
REQ-028 Same-cycle set and clear of the same register: set wins (bit ends 1).
REQ-029 ISSUE_VALID while DR_BUSY SHALL be ignored by the scoreboard (decode stalls; one outstanding write per register).
REQ-030 RSx_BUSY = busy[SRx] & ~(commit & WB_WRITE_REG & WB_DR==SRx); DR_BUSY computed the same way for ISSUE_DR.
REQ-031 WB_VALID while HOLD: no commit, no state change; Execution holds its outputs until WB_READY.
REQ-032 Latency: write visible via bypass in the commit cycle, via array the cycle after; CC visible the cycle after commit.

Reset
REQ-033 RESET_N low at a clock edge SHALL clear all registers to 0, all busy bits to 0, CC to CC_RESET; this overrides a simultaneous commit or issue.
REQ-034 Reset mid-stream SHALL discard any offered WB_VALID transfer; WB_READY stays ~HOLD (combinational).

Structure
REQ-035 Shared package holds DATA_W, REG_COUNT, CC_RESET and NPZ bit-position constants (N=2, P=1, Z=0), also used by Execution.
REQ-036 Scoreboard SHALL be one sub-module, regfile_scoreboard (busy bits, set/clear, busy lookups); array, bypass and CC remain in regfile_wb.

Verification
REQ-037 Reset, then read all 8 regs -> RSx_DATA 0x0000, CC 3'b001, all BUSY 0.
REQ-038 Commit DR=3, data 0x1234, SET_CC, NPZ 3'b010 with SR1=3 same cycle -> RS1_DATA 0x1234 that cycle; next cycle array read 0x1234, CC 3'b010.
REQ-039 HOLD=1 with WB_VALID, DR=5, data 0xBEEF -> WB_READY 0, reg5 unchanged; drop HOLD -> commit next edge.
REQ-040 Issue DR=2 -> busy; SR1=2 gives RS1_BUSY 1; commit DR=2 -> RS1_BUSY 0 in commit cycle, bit 0 after.
REQ-041 Same cycle: commit DR=4 and issue DR=4 (bit was set, DR_BUSY 0 via REQ-030) -> busy[4]=1 after edge.
REQ-042 RESET_N low while committing DR=1, 0xFFFF -> reg1 0x0000, CC 3'b001 after edge.
